ov5640_ddr_wr_ctrl: RTL

- AXI4 write-master sequencer between the camera packing/FIFO stage and the DDR controller.
- Per frame: selects a frame buffer from a ring of NUM_BUF, issues fixed-length INCR bursts at increasing addresses and forwards the 128-bit beat stream onto the W channel.
- Tracks B responses and publishes the last completed buffer index to the read side.

---
 rtl/ov5640_ddr_wr_ctrl.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/ov5640_ddr_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ov5640_ddr_wr_ctrl
// Purpose  : AXI4 write-master sequencer. Writes each camera frame into one
//            buffer of a ring using fixed-length INCR bursts, tracks B
//            responses and publishes the last completed buffer index.
// Revision : 1.0  initial release
// ============================================================================
module ov5640_ddr_wr_ctrl #(
    parameter int          ADDR_W       = 32,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter logic [31:0] FRAME_STRIDE = 32'h0040_0000,
    parameter int          NUM_BUF      = 3,
    parameter int          FRAME_BEATS  = 172800,
    parameter int          BURST_LEN    = 64,
    parameter int          MAX_OUTST    = 4
) (
    input  logic              axi_clk,
    input  logic              axi_rst,
    input  logic              s_vsync,
    output logic [19:0]       data_len,
    input  logic [127:0]      s_data,
    input  logic              s_data_valid,
    input  logic              s_data_last,
    output logic              s_data_ready,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic [7:0]        m_awlen,
    output logic [2:0]        m_awsize,
    output logic [1:0]        m_awburst,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [127:0]      m_wdata,
    output logic [15:0]       m_wstrb,
    output logic              m_wlast,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic              frame_done,
    output logic [1:0]        rd_buf_idx,
    output logic              rd_buf_vld,
    output logic [2:0]        err_flags
);

    localparam logic [3:0]        MAX_O       = 4'(MAX_OUTST);
    localparam logic [7:0]        LAST_BEAT   = 8'(BURST_LEN - 1);
    localparam logic [31:0]       BURST_L32   = 32'(BURST_LEN);
    localparam logic [31:0]       FRAME_B32   = 32'(FRAME_BEATS);
    localparam logic [1:0]        LAST_BUF    = 2'(NUM_BUF - 1);
    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * 16);
    localparam logic [ADDR_W-1:0] BASE_A      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STRIDE_A    = ADDR_W'(FRAME_STRIDE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_AW    = 2'd1,
        ST_W     = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_vs_q;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_beats_left;
    logic [7:0]         r_beat_cnt;
    logic [3:0]         r_outst;
    logic [1:0]         r_wr_buf;
    logic               r_pad;       // current burst is being padded after an abort
    logic               r_abort;     // FLUSH is an abort flush: restart same buffer
    logic               r_vs_pend;   // frame start seen while flushing
    logic               r_bready;
    logic               r_frame_done;
    logic [1:0]         r_rd_buf_idx;
    logic               r_rd_buf_vld;
    logic [2:0]         r_err;

    logic               w_vs_rise;
    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_b_hs;
    logic               w_burst_end;
    logic               w_flush_done;
    logic               w_start;
    logic               w_abort_evt;
    logic [1:0]         w_next_buf;
    logic [1:0]         w_start_buf;
    logic [ADDR_W-1:0]  w_start_addr;

    assign w_vs_rise    = s_vsync & ~r_vs_q;
    assign w_aw_hs      = m_awvalid & m_awready;
    assign w_w_hs       = m_wvalid & m_wready;
    assign w_b_hs       = m_bvalid & r_bready;
    assign w_burst_end  = w_w_hs & m_wlast;
    assign w_flush_done = (r_state == ST_FLUSH) && (r_outst == 4'd0);
    assign w_abort_evt  = w_vs_rise && ((r_state == ST_AW) || (r_state == ST_W));
    assign w_start      = (w_next_state == ST_AW) &&
                          ((r_state == ST_IDLE) || (r_state == ST_FLUSH));
    assign w_next_buf   = (r_wr_buf == LAST_BUF) ? 2'd0 : r_wr_buf + 2'd1;
    // A normal completion advances the ring in the same cycle a new frame may start.
    assign w_start_buf  = ((r_state == ST_FLUSH) && !r_abort) ? w_next_buf : r_wr_buf;
    assign w_start_addr = BASE_A + ({{(ADDR_W-2){1'b0}}, w_start_buf} * STRIDE_A);

    assign data_len   = 20'(BURST_LEN);
    assign m_awsize   = 3'b100;
    assign m_awburst  = 2'b01;
    assign m_awaddr   = r_addr;
    assign m_bready   = r_bready;
    assign frame_done = r_frame_done;
    assign rd_buf_idx = r_rd_buf_idx;
    assign rd_buf_vld = r_rd_buf_vld;
    assign err_flags  = r_err;

    // State register.
    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) r_state <= ST_IDLE;
        else         r_state <= w_next_state;
    end

    // Next-state decode and AXI channel outputs.
    always_comb begin
        w_next_state = r_state;
        m_awvalid    = 1'b0;
        m_awlen      = 8'd0;
        m_wvalid     = 1'b0;
        m_wdata      = '0;
        m_wstrb      = 16'h0000;
        m_wlast      = 1'b0;
        s_data_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_vs_rise) w_next_state = ST_AW;
            end
            ST_AW: begin
                // Once raised, awvalid stays up: outst cannot grow while waiting here.
                m_awvalid = (r_outst < MAX_O);
                m_awlen   = LAST_BEAT;
                if (w_vs_rise && !m_awvalid)       w_next_state = ST_FLUSH;
                else if (m_awvalid && m_awready)   w_next_state = ST_W;
            end
            ST_W: begin
                m_wlast = (r_beat_cnt == LAST_BEAT);
                if (r_pad) begin
                    m_wvalid = 1'b1;
                end else begin
                    m_wvalid     = s_data_valid;
                    m_wdata      = s_data;
                    m_wstrb      = 16'hFFFF;
                    s_data_ready = m_wready;
                end
                if (m_wvalid && m_wready && m_wlast) begin
                    if (r_pad || w_vs_rise || (r_beats_left == BURST_L32))
                        w_next_state = ST_FLUSH;
                    else
                        w_next_state = ST_AW;
                end
            end
            ST_FLUSH: begin
                if (r_outst == 4'd0)
                    w_next_state = (r_abort || r_vs_pend || w_vs_rise) ? ST_AW : ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Address/beat bookkeeping, outstanding count, ring pointer and status.
    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            r_vs_q       <= 1'b0;
            r_addr       <= '0;
            r_beats_left <= 32'd0;
            r_beat_cnt   <= 8'd0;
            r_outst      <= 4'd0;
            r_wr_buf     <= 2'd0;
            r_pad        <= 1'b0;
            r_abort      <= 1'b0;
            r_vs_pend    <= 1'b0;
            r_bready     <= 1'b0;
            r_frame_done <= 1'b0;
            r_rd_buf_idx <= 2'd0;
            r_rd_buf_vld <= 1'b0;
            r_err        <= 3'b000;
        end else begin
            r_vs_q       <= s_vsync;
            r_bready     <= 1'b1;
            r_frame_done <= 1'b0;

            if (w_start) begin
                r_addr       <= w_start_addr;
                r_beats_left <= FRAME_B32;
            end else begin
                if (w_aw_hs)     r_addr       <= r_addr + BURST_BYTES;
                if (w_burst_end) r_beats_left <= r_beats_left - BURST_L32;
            end

            if (w_w_hs) r_beat_cnt <= m_wlast ? 8'd0 : r_beat_cnt + 8'd1;

            case ({w_aw_hs, w_b_hs})
                2'b10:   r_outst <= r_outst + 4'd1;
                2'b01:   r_outst <= r_outst - 4'd1;
                default: r_outst <= r_outst;
            endcase

            if (w_next_state == ST_FLUSH) r_pad <= 1'b0;
            else if (w_abort_evt)         r_pad <= 1'b1;

            if (w_abort_evt)       r_abort <= 1'b1;
            else if (w_flush_done) r_abort <= 1'b0;

            if (w_flush_done)                               r_vs_pend <= 1'b0;
            else if ((r_state == ST_FLUSH) && w_vs_rise)    r_vs_pend <= 1'b1;

            if (w_flush_done && !r_abort) begin
                r_frame_done <= 1'b1;
                r_rd_buf_idx <= r_wr_buf;
                r_rd_buf_vld <= 1'b1;
                r_wr_buf     <= w_next_buf;
            end

            if (w_b_hs && (m_bresp != 2'b00))                      r_err[2] <= 1'b1;
            if (w_w_hs && !r_pad && (s_data_last != m_wlast))      r_err[1] <= 1'b1;
            if (w_abort_evt)                                       r_err[0] <= 1'b1;
        end
    end

endmodule
`default_nettype wire
